jt51_reg_file: RTL and testbench
================================

# jt51_reg_file

Per-slot parameter store and slot sequencer for the JT51 (YM2151-compatible) FM core. It sits behind the memory-mapped register decoder and holds the 8 channel and 32 operator parameter sets. Each parameter set is written when the sequencer reaches the target slot. Parameters stream out time-multiplexed, one slot per `cen`, at the pipeline stage where the operator datapath consumes them.

## Interface
Parameters: none.
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `cen` in 1: slot-advance clock enable (P1)
- `din` in 8: register data byte
- `up_rl`, `up_kc`, `up_kf`, `up_pms`, `up_dt1`, `up_tl`, `up_ks`, `up_amsen`, `up_dt2`, `up_d1l`, `up_keyon` in 1 each: update requests; level, held until the next data write
- `op` in 2: target operator (0=M1, 1=M2, 2=C1, 3=C2)
- `ch` in 3: target channel
- `csm` in 1: CSM key-on enable
- `overflow_A` in 1: timer A overflow
- Channel outputs (stage I unless noted): `rl_I`[2], `fb_II`[3], `con_I`[3], `kc_I`[7], `kf_I`[6], `pms_I`[3], `ams_VII`[2]
- Operator outputs: `dt1_II`[3], `mul_VI`[4], `tl_VII`[7], `ks_III`[2], `arate_II`[5], `amsen_VII`[1], `rate1_II`[5], `dt2_I`[2], `rate2_II`[5], `d1l_I`[4], `rrate_II`[4], `keyon_II`[1]
- Sequencer outputs: `cur_op`[2], `op31_no`, `op31_acc`, `zero`, `m1_enters`, `m2_enters`, `c1_enters`, `c2_enters`
- Routing outputs: `use_prevprev1`, `use_internal_x`, `use_internal_y`, `use_prev2`, `use_prev1` (all 1 bit)

## Operation
- Slot counter `cur`[4:0] increments on each `cen` and wraps 31→0.
  - `cur_op` = `cur[4:3]`; current channel = `cur[2:0]`.
  - `zero` = (`cur`==0).
- Target slot = {`op`,`ch`}.
- On `cen`, if an update request is high and `cur` equals the target slot, the fields below are captured from `din`.
- Channel fields are stored per channel, indexed by `ch` only:
  - `up_rl`: RL=`din[7:6]`, FB=`din[5:3]`, CON=`din[2:0]`
  - `up_kc`: KC=`din[6:0]`
  - `up_kf`: KF=`din[7:2]`
  - `up_pms`: PMS=`din[6:4]`, AMS=`din[1:0]`
- Operator fields are stored per slot:
  - `up_dt1`: DT1=`din[6:4]`, MUL=`din[3:0]`
  - `up_tl`: TL=`din[6:0]`
  - `up_ks`: KS=`din[7:6]`, AR=`din[4:0]`
  - `up_amsen`: AMSEN=`din[7]`, D1R=`din[4:0]`
  - `up_dt2`: DT2=`din[7:6]`, D2R=`din[4:0]`
  - `up_d1l`: D1L=`din[7:4]`, RR=`din[3:0]`
- `up_keyon` ignores `op`/`ch`.
  - Channel is `din[2:0]`.
  - Slot key-on bits are taken from `din[3]`=M1, `din[4]`=C1, `din[5]`=M2, `din[6]`=C2; each is written when `cur` reaches that slot.
- CSM:
  - `csm`&`overflow_A` sets a pending flag.
  - At the next `zero`, a 32-slot pass begins during which `keyon_II` is forced to 1.
  - The flag clears at the end of that pass.
- Routing flags describe the modulation source of the stage-II slot, given its CON and compute order M1,M2,C1,C2.
  - `use_prev1`: M2←M1 (CON 1,5); C2←C1 (CON 3).
  - `use_prevprev1`: C1←M1 (CON 0,3,4,5,6).
  - `use_prev2`: C2←M2 (CON 0,1,2,3,4).
  - `use_internal_x`: C2←held M1 (CON 2,5).
  - `use_internal_y`: M2←previous-sample C1 (CON 0,1,2).
  - All routing flags are 0 for M1 and for CON 7.
- Enters outputs: `m1_enters`/`m2_enters`/`c1_enters`/`c2_enters` are asserted when the stage-II slot's op is 0/1/2/3 respectively.
- `op31_no`: asserted when the stage-I slot is 31.
- `op31_acc`: asserted when the stage-I slot is a carrier for its CON.
  - C2 is always a carrier.
  - C1 is a carrier for CON≥4.
  - M2 is a carrier for CON≥5.
  - M1 is a carrier for CON 7 only.

## Timing
- Stage-k outputs present slot (`cur`−(k−1)) mod 32, with channel fields indexed by that slot's `[2:0]`; they change only on `cen`.
- Update latency is ≤32 `cen` from the request rising; held requests rewrite identical data harmlessly.
- Reset:
  - `cur`=0, so `zero`=1.
  - All stored fields are 0, key-on bits are 0, and the CSM flag is cleared.
  - All other outputs are 0.
- Reset mid-pass discards the pending CSM and any partial updates.

## Structure
- Shared package holds:
  - op encodings M1=0, M2=1, C1=2, C2=3
  - key-on bit positions
  - field bit ranges
- Natural sub-module: `jt51_slot_cnt` (slot counter, `zero`, `cur_op`).
- Debug demultiplexers are excluded from synthesis.

## Test plan
- Reset → `zero`=1, every output 0; 32 `cen` → `zero` pulses once per 32.
- `up_tl`, `op`=2, `ch`=5, `din`=0x55 → `tl_VII`=0x55 when slot 21 reaches stage VII; other slots stay 0.
- `up_rl`, `ch`=3, `din`=0xC7 → `rl_I`=3 and `con_I`=7 for all 4 slots of channel 3; `fb_II`=0.
- `up_keyon`, `din`=0x7A → `keyon_II`=1 for all 4 slots of channel 2; then `din`=0x02 → all 0.
- `csm`=1, one `overflow_A` pulse → `keyon_II`=1 for the 32 slots after the next `zero`, then stored values.
- CON=2 on channel 0 → C2 slot has `use_internal_x`=`use_prev2`=1; M2 slot has `use_internal_y`=1.

Source files
------------

// File: rtl/jt51_reg_file_pkg.sv
// Shared definitions for the JT51 register file: operator encodings,
// key-on bit positions, din field positions and stored parameter layouts.
package jt51_reg_file_pkg;

  typedef enum logic [1:0] {
    OP_M1 = 2'd0,
    OP_M2 = 2'd1,
    OP_C1 = 2'd2,
    OP_C2 = 2'd3
  } op_e;

  // key-on byte: slot enables are not in op order
  localparam int KON_M1 = 3;
  localparam int KON_C1 = 4;
  localparam int KON_M2 = 5;
  localparam int KON_C2 = 6;

  localparam int RL_LO   = 6;
  localparam int FB_LO   = 3;
  localparam int CON_LO  = 0;
  localparam int KC_LO   = 0;
  localparam int KF_LO   = 2;
  localparam int PMS_LO  = 4;
  localparam int AMS_LO  = 0;
  localparam int DT1_LO  = 4;
  localparam int MUL_LO  = 0;
  localparam int TL_LO   = 0;
  localparam int KS_LO   = 6;
  localparam int AMSEN_B = 7;
  localparam int DT2_LO  = 6;
  localparam int D1L_LO  = 4;
  localparam int RR_LO   = 0;
  localparam int RATE_LO = 0;

  typedef struct packed {
    logic [1:0] rl;
    logic [2:0] fb;
    logic [2:0] con;
    logic [6:0] kc;
    logic [5:0] kf;
    logic [2:0] pms;
    logic [1:0] ams;
  } ch_regs_t;

  typedef struct packed {
    logic [2:0] dt1;
    logic [3:0] mul;
    logic [6:0] tl;
    logic [1:0] ks;
    logic [4:0] ar;
    logic       amsen;
    logic [4:0] d1r;
    logic [1:0] dt2;
    logic [4:0] d2r;
    logic [3:0] d1l;
    logic [3:0] rr;
  } op_regs_t;

  function automatic logic kon_bit(input logic [7:0] d, input logic [1:0] o);
    case (op_e'(o))
      OP_M1:   return d[KON_M1];
      OP_M2:   return d[KON_M2];
      OP_C1:   return d[KON_C1];
      default: return d[KON_C2];
    endcase
  endfunction

  // operator output reaches the accumulator for this connection
  function automatic logic is_carrier(input logic [1:0] o, input logic [2:0] con);
    case (op_e'(o))
      OP_M1:   return con == 3'd7;
      OP_M2:   return con >= 3'd5;
      OP_C1:   return con >= 3'd4;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// 32-slot sequencer: advances one slot per cen, wrapping 31 -> 0.
import jt51_reg_file_pkg::*;

module jt51_slot_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  output logic [4:0] cur,
  output logic [1:0] cur_op,
  output logic       zero
);

  logic [4:0] cur_q, cur_d;

  always_comb begin
    cur_d = cur_q;
    if (cen) cur_d = cur_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_q <= '0;
    else     cur_q <= cur_d;
  end

  assign cur    = cur_q;
  assign cur_op = cur_q[4:3];
  assign zero   = (cur_q == 5'd0);

endmodule

// File: rtl/jt51_reg_file.sv
// JT51 per-slot parameter store: captures register writes when the sequencer
// reaches the target slot and streams parameters out at each consuming stage.
import jt51_reg_file_pkg::*;

module jt51_reg_file (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       up_rl,
  input  logic       up_kc,
  input  logic       up_kf,
  input  logic       up_pms,
  input  logic       up_dt1,
  input  logic       up_tl,
  input  logic       up_ks,
  input  logic       up_amsen,
  input  logic       up_dt2,
  input  logic       up_d1l,
  input  logic       up_keyon,
  input  logic [1:0] op,
  input  logic [2:0] ch,
  input  logic       csm,
  input  logic       overflow_A,
  output logic [1:0] rl_I,
  output logic [2:0] fb_II,
  output logic [2:0] con_I,
  output logic [6:0] kc_I,
  output logic [5:0] kf_I,
  output logic [2:0] pms_I,
  output logic [1:0] ams_VII,
  output logic [2:0] dt1_II,
  output logic [3:0] mul_VI,
  output logic [6:0] tl_VII,
  output logic [1:0] ks_III,
  output logic [4:0] arate_II,
  output logic       amsen_VII,
  output logic [4:0] rate1_II,
  output logic [1:0] dt2_I,
  output logic [4:0] rate2_II,
  output logic [3:0] d1l_I,
  output logic [3:0] rrate_II,
  output logic       keyon_II,
  output logic [1:0] cur_op,
  output logic       op31_no,
  output logic       op31_acc,
  output logic       zero,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       use_prevprev1,
  output logic       use_internal_x,
  output logic       use_internal_y,
  output logic       use_prev2,
  output logic       use_prev1
);

  logic [4:0] cur, s2, s3, s6, s7;

  jt51_slot_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .cur    (cur),
    .cur_op (cur_op),
    .zero   (zero)
  );

  // slot seen by stage k is cur-(k-1)
  assign s2 = cur - 5'd1;
  assign s3 = cur - 5'd2;
  assign s6 = cur - 5'd5;
  assign s7 = cur - 5'd6;

  ch_regs_t [7:0]  ch_q,  ch_d;
  op_regs_t [31:0] opr_q, opr_d;
  logic     [31:0] kon_q, kon_d;
  logic            csm_pend_q, csm_pend_d;
  logic            csm_on_q, csm_on_d;
  logic            run_q, run_d;
  logic            hit;

  assign hit = cen && (cur == {op, ch});

  always_comb begin
    ch_d  = ch_q;
    opr_d = opr_q;
    kon_d = kon_q;
    if (hit) begin
      if (up_rl) begin
        ch_d[ch].rl  = din[RL_LO +: 2];
        ch_d[ch].fb  = din[FB_LO +: 3];
        ch_d[ch].con = din[CON_LO +: 3];
      end
      if (up_kc) ch_d[ch].kc = din[KC_LO +: 7];
      if (up_kf) ch_d[ch].kf = din[KF_LO +: 6];
      if (up_pms) begin
        ch_d[ch].pms = din[PMS_LO +: 3];
        ch_d[ch].ams = din[AMS_LO +: 2];
      end
      if (up_dt1) begin
        opr_d[cur].dt1 = din[DT1_LO +: 3];
        opr_d[cur].mul = din[MUL_LO +: 4];
      end
      if (up_tl) opr_d[cur].tl = din[TL_LO +: 7];
      if (up_ks) begin
        opr_d[cur].ks = din[KS_LO +: 2];
        opr_d[cur].ar = din[RATE_LO +: 5];
      end
      if (up_amsen) begin
        opr_d[cur].amsen = din[AMSEN_B];
        opr_d[cur].d1r   = din[RATE_LO +: 5];
      end
      if (up_dt2) begin
        opr_d[cur].dt2 = din[DT2_LO +: 2];
        opr_d[cur].d2r = din[RATE_LO +: 5];
      end
      if (up_d1l) begin
        opr_d[cur].d1l = din[D1L_LO +: 4];
        opr_d[cur].rr  = din[RR_LO +: 4];
      end
    end
    // key-on names its channel in din, so each of the 4 slots is caught in turn
    if (cen && up_keyon && (cur[2:0] == din[2:0]))
      kon_d[cur] = kon_bit(din, cur[4:3]);
  end

  // CSM pass spans exactly one lap, from one zero-crossing to the next
  always_comb begin
    csm_pend_d = csm_pend_q;
    csm_on_d   = csm_on_q;
    run_d      = run_q | cen;
    if (cen && zero) begin
      csm_on_d = csm_pend_q && !csm_on_q;
      if (csm_on_q) csm_pend_d = 1'b0;
    end
    if (csm && overflow_A) csm_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      opr_q      <= '0;
      kon_q      <= '0;
      csm_pend_q <= 1'b0;
      csm_on_q   <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      opr_q      <= opr_d;
      kon_q      <= kon_d;
      csm_pend_q <= csm_pend_d;
      csm_on_q   <= csm_on_d;
      run_q      <= run_d;
    end
  end

  assign rl_I      = ch_q[cur[2:0]].rl;
  assign con_I     = ch_q[cur[2:0]].con;
  assign kc_I      = ch_q[cur[2:0]].kc;
  assign kf_I      = ch_q[cur[2:0]].kf;
  assign pms_I     = ch_q[cur[2:0]].pms;
  assign fb_II     = ch_q[s2[2:0]].fb;
  assign ams_VII   = ch_q[s7[2:0]].ams;
  assign dt2_I     = opr_q[cur].dt2;
  assign d1l_I     = opr_q[cur].d1l;
  assign dt1_II    = opr_q[s2].dt1;
  assign arate_II  = opr_q[s2].ar;
  assign rate1_II  = opr_q[s2].d1r;
  assign rate2_II  = opr_q[s2].d2r;
  assign rrate_II  = opr_q[s2].rr;
  assign ks_III    = opr_q[s3].ks;
  assign mul_VI    = opr_q[s6].mul;
  assign tl_VII    = opr_q[s7].tl;
  assign amsen_VII = opr_q[s7].amsen;
  assign keyon_II  = kon_q[s2] | csm_on_q;
  assign op31_no   = (cur == 5'd31);
  assign op31_acc  = is_carrier(cur[4:3], ch_q[cur[2:0]].con);

  logic [2:0] con2;
  assign con2 = ch_q[s2[2:0]].con;

  // stage II shows slot 31 straight out of reset; hold routing quiet until the first cen
  always_comb begin
    {m1_enters, m2_enters, c1_enters, c2_enters} = 4'b0;
    {use_prev1, use_prevprev1, use_prev2, use_internal_x, use_internal_y} = 5'b0;
    if (run_q) begin
      case (op_e'(s2[4:3]))
        OP_M1: m1_enters = 1'b1;
        OP_M2: begin
          m2_enters      = 1'b1;
          use_prev1      = (con2 == 3'd1) || (con2 == 3'd5);
          use_internal_y = (con2 <= 3'd2);
        end
        OP_C1: begin
          c1_enters     = 1'b1;
          use_prevprev1 = (con2 == 3'd0) || ((con2 >= 3'd3) && (con2 <= 3'd6));
        end
        default: begin
          c2_enters      = 1'b1;
          use_prev1      = (con2 == 3'd3);
          use_prev2      = (con2 <= 3'd4);
          use_internal_x = (con2 == 3'd2) || (con2 == 3'd5);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_reg_file.sv
// Bench for jt51_reg_file: slot-level array model checked every cycle plus
// directed write scenarios with literal expectations.
module tb_jt51_reg_file;

  logic        clk = 1'b0, rst = 1'b0, cen = 1'b0;
  logic [7:0]  din = '0;
  logic [10:0] ups = '0;  // rl kc kf pms dt1 tl ks amsen dt2 d1l keyon
  logic [1:0]  op = '0;
  logic [2:0]  ch = '0;
  logic        csm = 1'b0, overflow_A = 1'b0;

  logic [1:0] rl_I, ams_VII, ks_III, dt2_I, cur_op;
  logic [2:0] fb_II, con_I, pms_I, dt1_II;
  logic [6:0] kc_I, tl_VII;
  logic [5:0] kf_I;
  logic [3:0] mul_VI, d1l_I, rrate_II;
  logic [4:0] arate_II, rate1_II, rate2_II;
  logic amsen_VII, keyon_II, op31_no, op31_acc, zero;
  logic m1_enters, m2_enters, c1_enters, c2_enters;
  logic use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;

  always #5 clk = ~clk;

  jt51_reg_file dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din),
    .up_rl(ups[0]), .up_kc(ups[1]), .up_kf(ups[2]), .up_pms(ups[3]),
    .up_dt1(ups[4]), .up_tl(ups[5]), .up_ks(ups[6]), .up_amsen(ups[7]),
    .up_dt2(ups[8]), .up_d1l(ups[9]), .up_keyon(ups[10]),
    .op(op), .ch(ch), .csm(csm), .overflow_A(overflow_A),
    .rl_I(rl_I), .fb_II(fb_II), .con_I(con_I), .kc_I(kc_I), .kf_I(kf_I),
    .pms_I(pms_I), .ams_VII(ams_VII), .dt1_II(dt1_II), .mul_VI(mul_VI),
    .tl_VII(tl_VII), .ks_III(ks_III), .arate_II(arate_II), .amsen_VII(amsen_VII),
    .rate1_II(rate1_II), .dt2_I(dt2_I), .rate2_II(rate2_II), .d1l_I(d1l_I),
    .rrate_II(rrate_II), .keyon_II(keyon_II), .cur_op(cur_op), .op31_no(op31_no),
    .op31_acc(op31_acc), .zero(zero), .m1_enters(m1_enters), .m2_enters(m2_enters),
    .c1_enters(c1_enters), .c2_enters(c2_enters), .use_prevprev1(use_prevprev1),
    .use_internal_x(use_internal_x), .use_internal_y(use_internal_y),
    .use_prev2(use_prev2), .use_prev1(use_prev1)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: per-slot / per-channel arrays ----------------
  int m_cur, m_run, m_pend, m_left, md, mc;
  int m_rl[8], m_fb[8], m_con[8], m_kc[8], m_kf[8], m_pms[8], m_ams[8];
  int m_dt1[32], m_mul[32], m_tl[32], m_ks[32], m_ar[32], m_amsen[32];
  int m_d1r[32], m_dt2[32], m_d2r[32], m_d1l[32], m_rr[32], m_kon[32];
  int kpos[4]    = '{3, 5, 4, 6};
  int car_min[4] = '{7, 5, 4, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = 0; m_run = 0; m_pend = 0; m_left = 0;
      for (int i = 0; i < 8; i++) begin
        m_rl[i] = 0; m_fb[i] = 0; m_con[i] = 0; m_kc[i] = 0; m_kf[i] = 0; m_pms[i] = 0; m_ams[i] = 0;
      end
      for (int i = 0; i < 32; i++) begin
        m_dt1[i] = 0; m_mul[i] = 0; m_tl[i] = 0; m_ks[i] = 0; m_ar[i] = 0; m_amsen[i] = 0;
        m_d1r[i] = 0; m_dt2[i] = 0; m_d2r[i] = 0; m_d1l[i] = 0; m_rr[i] = 0; m_kon[i] = 0;
      end
    end else begin
      if (cen) begin
        md = int'(din);
        mc = int'(ch);
        if (m_cur == int'(op) * 8 + mc) begin
          if (ups[0]) begin m_rl[mc] = md >> 6; m_fb[mc] = (md >> 3) & 7; m_con[mc] = md & 7; end
          if (ups[1]) m_kc[mc] = md & 127;
          if (ups[2]) m_kf[mc] = md >> 2;
          if (ups[3]) begin m_pms[mc] = (md >> 4) & 7; m_ams[mc] = md & 3; end
          if (ups[4]) begin m_dt1[m_cur] = (md >> 4) & 7; m_mul[m_cur] = md & 15; end
          if (ups[5]) m_tl[m_cur] = md & 127;
          if (ups[6]) begin m_ks[m_cur] = md >> 6; m_ar[m_cur] = md & 31; end
          if (ups[7]) begin m_amsen[m_cur] = md >> 7; m_d1r[m_cur] = md & 31; end
          if (ups[8]) begin m_dt2[m_cur] = md >> 6; m_d2r[m_cur] = md & 31; end
          if (ups[9]) begin m_d1l[m_cur] = md >> 4; m_rr[m_cur] = md & 15; end
        end
        if (ups[10] && (m_cur % 8) == (md & 7)) m_kon[m_cur] = (md >> kpos[m_cur / 8]) & 1;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_pend = 0;
        end else if (m_cur == 0 && m_pend != 0) m_left = 32;
        m_cur = (m_cur + 1) % 32;
        m_run = 1;
      end
      if (csm && overflow_A) m_pend = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int e2, e3, e6, e7, o2, cn;

  always @(negedge clk) begin
    if (!rst) begin
      e2 = (m_cur + 31) % 32; e3 = (m_cur + 30) % 32;
      e6 = (m_cur + 27) % 32; e7 = (m_cur + 26) % 32;
      o2 = e2 / 8; cn = m_con[e2 % 8];
      check("rl_I", int'(rl_I), m_rl[m_cur % 8]);
      check("con_I", int'(con_I), m_con[m_cur % 8]);
      check("kc_I", int'(kc_I), m_kc[m_cur % 8]);
      check("kf_I", int'(kf_I), m_kf[m_cur % 8]);
      check("pms_I", int'(pms_I), m_pms[m_cur % 8]);
      check("fb_II", int'(fb_II), m_fb[e2 % 8]);
      check("ams_VII", int'(ams_VII), m_ams[e7 % 8]);
      check("dt1_II", int'(dt1_II), m_dt1[e2]);
      check("mul_VI", int'(mul_VI), m_mul[e6]);
      check("tl_VII", int'(tl_VII), m_tl[e7]);
      check("ks_III", int'(ks_III), m_ks[e3]);
      check("arate_II", int'(arate_II), m_ar[e2]);
      check("amsen_VII", int'(amsen_VII), m_amsen[e7]);
      check("rate1_II", int'(rate1_II), m_d1r[e2]);
      check("dt2_I", int'(dt2_I), m_dt2[m_cur]);
      check("rate2_II", int'(rate2_II), m_d2r[e2]);
      check("d1l_I", int'(d1l_I), m_d1l[m_cur]);
      check("rrate_II", int'(rrate_II), m_rr[e2]);
      check("keyon_II", int'(keyon_II), (m_left > 0) ? 1 : m_kon[e2]);
      check("cur_op", int'(cur_op), m_cur / 8);
      check("zero", int'(zero), int'(m_cur == 0));
      check("op31_no", int'(op31_no), int'(m_cur == 31));
      check("op31_acc", int'(op31_acc), int'(m_con[m_cur % 8] >= car_min[m_cur / 8]));
      check("m1_enters", int'(m1_enters), int'(m_run != 0 && o2 == 0));
      check("m2_enters", int'(m2_enters), int'(m_run != 0 && o2 == 1));
      check("c1_enters", int'(c1_enters), int'(m_run != 0 && o2 == 2));
      check("c2_enters", int'(c2_enters), int'(m_run != 0 && o2 == 3));
      check("use_prev1", int'(use_prev1),
            int'(m_run != 0 && ((o2 == 1 && ((8'h22 >> cn) & 1) != 0) || (o2 == 3 && cn == 3))));
      check("use_prevprev1", int'(use_prevprev1), int'(m_run != 0 && o2 == 2 && ((8'h79 >> cn) & 1) != 0));
      check("use_prev2", int'(use_prev2), int'(m_run != 0 && o2 == 3 && cn <= 4));
      check("use_internal_x", int'(use_internal_x), int'(m_run != 0 && o2 == 3 && (cn == 2 || cn == 5)));
      check("use_internal_y", int'(use_internal_y), int'(m_run != 0 && o2 == 1 && cn <= 2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
  endtask

  task automatic seek(input int target);
    int k = 0;
    while (m_cur != target && k < 64) begin tick(); k++; end
    check("seek_slot", m_cur, target);
  endtask

  task automatic write_reg(input int f, input int o, input int c, input int d);
    @(negedge clk);
    op = 2'(o); ch = 3'(c); din = 8'(d);
    ups = '0; ups[f] = 1'b1;
    repeat (32) tick();
    ups = '0;
  endtask

  int zc;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_zero", int'(zero), 1);
    check("rst_c2_enters", int'(c2_enters), 0);
    check("rst_use_prev2", int'(use_prev2), 0);
    check("rst_keyon", int'(keyon_II), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_zero", int'(zero), 1);
    check("post_rst_cur_op", int'(cur_op), 0);

    zc = 0;
    repeat (32) begin tick(); zc += int'(zero); end
    check("zero_pulses_per_lap", zc, 1);

    write_reg(5, 2, 5, 8'h55);
    seek(27); check("tl_slot21", int'(tl_VII), 8'h55);
    tick();   check("tl_slot22", int'(tl_VII), 0);

    write_reg(0, 0, 3, 8'hC7);
    for (int k = 0; k < 4; k++) begin
      seek(3 + 8 * k);
      check("rl_ch3", int'(rl_I), 3);
      check("con_ch3", int'(con_I), 7);
      check("fb_ch3", int'(fb_II), 0);
    end

    write_reg(10, 0, 0, 8'h7A);
    for (int k = 0; k < 4; k++) begin seek(3 + 8 * k); check("keyon_ch2_on", int'(keyon_II), 1); end
    write_reg(10, 0, 0, 8'h02);
    for (int k = 0; k < 4; k++) begin seek(3 + 8 * k); check("keyon_ch2_off", int'(keyon_II), 0); end

    write_reg(1, 1, 6, 8'h7F);
    write_reg(2, 0, 1, 8'hFC);
    write_reg(3, 3, 4, 8'h73);
    write_reg(4, 1, 2, 8'h5A);
    write_reg(6, 3, 7, 8'hDF);
    write_reg(7, 0, 0, 8'h93);
    write_reg(8, 2, 1, 8'h8C);
    write_reg(9, 1, 7, 8'hA6);
    write_reg(0, 2, 1, 8'h2D);
    write_reg(0, 0, 4, 8'h43);
    write_reg(0, 1, 5, 8'h36);
    seek(0); check("arate_slot31", int'(arate_II), 31);
    seek(1); check("ks_slot31", int'(ks_III), 3);
    repeat (32) tick();

    write_reg(0, 0, 0, 8'h02);
    seek(25);
    check("con2_c2_internal_x", int'(use_internal_x), 1);
    check("con2_c2_prev2", int'(use_prev2), 1);
    check("con2_c2_enters", int'(c2_enters), 1);
    seek(9);
    check("con2_m2_internal_y", int'(use_internal_y), 1);
    check("con2_m2_enters", int'(m2_enters), 1);
    check("con2_m2_prev1", int'(use_prev1), 0);

    seek(5);
    @(negedge clk); csm = 1'b1; overflow_A = 1'b1;
    @(negedge clk); overflow_A = 1'b0;
    zc = 0;
    repeat (64) begin tick(); zc += int'(keyon_II); end
    check("csm_forced_slots", zc, 32);
    csm = 1'b0;

    @(negedge clk); csm = 1'b1; overflow_A = 1'b1;
    @(negedge clk); overflow_A = 1'b0; csm = 1'b0;
    seek(0); tick(); tick(); tick();
    check("csm_mid_pass", int'(keyon_II), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pass_keyon", int'(keyon_II), 0);
    check("rst_mid_pass_zero", int'(zero), 1);
    rst = 1'b0;
    zc = 0;
    repeat (64) begin tick(); zc += int'(keyon_II); end
    check("csm_after_reset", zc, 0);
    seek(27); check("tl_after_reset", int'(tl_VII), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
